// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: six-phase hue wheel feeding the RGB PWM stage.
// Duty values only move on PWM period boundaries.
module rgb_fade_sequencer #(
   parameter  int PWM_INTERVAL = 1200,
   parameter  int STEP_SIZE    = 4,
   parameter  int STEP_PERIODS = 50,
   localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          pwm_wrap,
   output logic [DW-1:0] duty_r,
   output logic [DW-1:0] duty_g,
   output logic [DW-1:0] duty_b,
   output logic          update,
   output logic [2:0]    phase
);

   localparam int PCW =
      (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

   localparam logic [PCW-1:0] PC_LAST = PCW'(STEP_PERIODS - 1);
   localparam logic [DW-1:0]  FS      = DW'(PWM_INTERVAL);
   localparam logic [DW-1:0]  ZERO    = '0;
   localparam logic [DW:0]    STEP    = (DW + 1)'(STEP_SIZE);

   typedef enum logic [2:0] {
      PH_0 = 3'd0,
      PH_1 = 3'd1,
      PH_2 = 3'd2,
      PH_3 = 3'd3,
      PH_4 = 3'd4,
      PH_5 = 3'd5
   } phase_t;

   logic [PCW-1:0]  r_pc;
   logic [DW-1:0]   r_r;
   phase_t          r_ph;
   logic [DW-1:0]   r_duty_r;
   logic [DW-1:0]   r_duty_g;
   logic [DW-1:0]   r_duty_b;
   logic            r_update;

   logic            w_wrap;
   logic            w_tick;
   logic [DW:0]     w_sum;
   logic            w_roll;
   logic            w_ph_ok;
   phase_t          w_ph_succ;
   phase_t          w_ph_nxt;
   logic [DW-1:0]   w_r_nxt;
   logic [3*DW-1:0] w_duty_nxt;

   // Map a phase and ramp position onto {R, G, B}; codes 6/7 show pure red.
   function automatic logic [3*DW-1:0] decode(
      input phase_t        ph,
      input logic [DW-1:0] rr
   );
      logic [DW-1:0] rise;
      logic [DW-1:0] fall;
      rise = rr;
      fall = FS - rr;
      case (ph)
         PH_0:    decode = {FS,   rise, ZERO};
         PH_1:    decode = {fall, FS,   ZERO};
         PH_2:    decode = {ZERO, FS,   rise};
         PH_3:    decode = {ZERO, fall, FS  };
         PH_4:    decode = {rise, ZERO, FS  };
         PH_5:    decode = {FS,   ZERO, fall};
         default: decode = {FS,   ZERO, ZERO};
      endcase
   endfunction

   assign w_wrap  = enable && pwm_wrap;
   assign w_tick  = w_wrap && (r_pc == PC_LAST);
   assign w_sum   = {1'b0, r_r} + STEP;
   assign w_roll  = (w_sum >= {1'b0, FS});
   assign w_ph_ok = (r_ph <= PH_5);

   // Count PWM periods; only qualified wraps move the counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= '0;
      end else if (w_wrap) begin
         if (w_tick) begin
            r_pc <= '0;
         end else begin
            r_pc <= r_pc + 1'b1;
         end
      end
   end

   // Phase state register; ramp position moves with it on each tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph <= PH_0;
         r_r  <= '0;
      end else if (w_tick) begin
         r_ph <= w_ph_nxt;
         r_r  <= w_r_nxt;
      end
   end

   // Successor phase around the wheel, 5 wrapping back to 0.
   always_comb begin
      w_ph_succ = PH_0;
      case (r_ph)
         PH_0:    w_ph_succ = PH_1;
         PH_1:    w_ph_succ = PH_2;
         PH_2:    w_ph_succ = PH_3;
         PH_3:    w_ph_succ = PH_4;
         PH_4:    w_ph_succ = PH_5;
         PH_5:    w_ph_succ = PH_0;
         default: w_ph_succ = PH_0;
      endcase
   end

   // Next phase/ramp: step the ramp, roll into the next phase at full scale.
   always_comb begin
      w_ph_nxt = r_ph;
      w_r_nxt  = r_r;
      if (w_tick) begin
         if (w_roll) begin
            w_ph_nxt = w_ph_succ;
            w_r_nxt  = '0;
         end else begin
            w_r_nxt  = w_sum[DW-1:0];
         end
         if (!w_ph_ok) begin
            w_ph_nxt = PH_0;
            w_r_nxt  = '0;
         end
      end
   end

   // Decode the upcoming state so duties land on the same edge as the tick.
   always_comb begin
      w_duty_nxt = decode(w_ph_nxt, w_r_nxt);
   end

   // Duty registers and the update strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_duty_r <= FS;
         r_duty_g <= ZERO;
         r_duty_b <= ZERO;
         r_update <= 1'b0;
      end else begin
         r_update <= w_tick;
         if (w_tick) begin
            {r_duty_r, r_duty_g, r_duty_b} <= w_duty_nxt;
         end
      end
   end

   assign duty_r = r_duty_r;
   assign duty_g = r_duty_g;
   assign duty_b = r_duty_b;
   assign update = r_update;
   assign phase  = r_ph;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed checks of the hue wheel at F=12,
// with a second instance using a step of 5.
module tb_rgb_fade_sequencer;

   localparam int F  = 12;
   localparam int DW = $clog2(F + 1);

   logic          clk;
   logic          rst;
   logic          enable;
   logic          pwm_wrap;
   logic [DW-1:0] duty_r;
   logic [DW-1:0] duty_g;
   logic [DW-1:0] duty_b;
   logic          update;
   logic [2:0]    phase;
   logic [DW-1:0] d5_r;
   logic [DW-1:0] d5_g;
   logic [DW-1:0] d5_b;
   logic          d5_update;
   logic [2:0]    d5_phase;

   int n_vec;
   int n_err;
   int upd_cnt;
   int prev_r;
   int prev_g;
   int prev_b;
   int hold_r;
   int hold_g;
   int hold_b;

   rgb_fade_sequencer #(
      .PWM_INTERVAL(F),
      .STEP_SIZE   (4),
      .STEP_PERIODS(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .pwm_wrap(pwm_wrap),
      .duty_r  (duty_r),
      .duty_g  (duty_g),
      .duty_b  (duty_b),
      .update  (update),
      .phase   (phase)
   );

   rgb_fade_sequencer #(
      .PWM_INTERVAL(F),
      .STEP_SIZE   (5),
      .STEP_PERIODS(2)
   ) dut5 (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .pwm_wrap(pwm_wrap),
      .duty_r  (d5_r),
      .duty_g  (d5_g),
      .duty_b  (d5_b),
      .update  (d5_update),
      .phase   (d5_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count update pulses of the step-4 instance since the last reset.
   always @(negedge clk) begin
      if (rst) begin
         upd_cnt = 0;
      end else if (update === 1'b1) begin
         upd_cnt = upd_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_vec = n_vec + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_duty(
      input string tag,
      input int    er,
      input int    eg,
      input int    eb
   );
      chk({tag, "_r"}, 32'(duty_r), er);
      chk({tag, "_g"}, 32'(duty_g), eg);
      chk({tag, "_b"}, 32'(duty_b), eb);
   endtask

   // One PWM period: 11 idle clocks then a one-clock wrap pulse.
   // Returns on the negedge right after the wrap has been sampled.
   task automatic do_wrap();
      repeat (11) @(negedge clk);
      pwm_wrap = 1'b1;
      @(negedge clk);
      pwm_wrap = 1'b0;
   endtask

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   initial begin
      n_vec    = 0;
      n_err    = 0;
      upd_cnt  = 0;
      rst      = 1'b0;
      enable   = 1'b1;
      pwm_wrap = 1'b0;

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk_duty("rst_async", 12, 0, 0);
      chk("rst_update", 32'(update), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst5_g", 32'(d5_g), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // First steps.
      do_wrap();
      chk("w1_update", 32'(update), 0);
      do_wrap();
      chk("w2_update", 32'(update), 1);
      chk_duty("w2", 12, 4, 0);
      chk("w2_s5_g", 32'(d5_g), 5);
      @(negedge clk);
      chk("w2_update_1cyc", 32'(update), 0);
      do_wrap();
      chk("w3_update", 32'(update), 0);
      do_wrap();
      chk_duty("w4", 12, 8, 0);
      chk("w4_s5_g", 32'(d5_g), 10);
      do_wrap();
      do_wrap();
      chk("w6_phase", 32'(phase), 1);
      chk_duty("w6", 12, 12, 0);
      chk("w6_s5_phase", 32'(d5_phase), 1);
      chk("w6_s5_r", 32'(d5_r), 12);
      chk("w6_s5_g", 32'(d5_g), 12);
      chk("w6_s5_b", 32'(d5_b), 0);
      do_wrap();
      do_wrap();
      chk_duty("w8", 8, 12, 0);
      chk("w8_s5_r", 32'(d5_r), 7);

      // Remainder of the full wheel with range and slew checks per tick.
      prev_r = 8;
      prev_g = 12;
      prev_b = 0;
      for (int w = 9; w <= 36; w++) begin
         do_wrap();
         if ((w % 2) == 0) begin
            chk("wheel_rng_r", 32'(duty_r <= 12), 1);
            chk("wheel_rng_g", 32'(duty_g <= 12), 1);
            chk("wheel_rng_b", 32'(duty_b <= 12), 1);
            chk("wheel_slew_r", 32'(absdiff(int'(duty_r), prev_r) <= 4), 1);
            chk("wheel_slew_g", 32'(absdiff(int'(duty_g), prev_g) <= 4), 1);
            chk("wheel_slew_b", 32'(absdiff(int'(duty_b), prev_b) <= 4), 1);
            prev_r = int'(duty_r);
            prev_g = int'(duty_g);
            prev_b = int'(duty_b);
         end
         if (w == 18) begin
            chk("w18_phase", 32'(phase), 3);
            chk_duty("w18", 0, 12, 12);
         end
      end
      chk_duty("wheel_end", 12, 0, 0);
      chk("wheel_end_phase", 32'(phase), 0);
      @(negedge clk);
      chk("wheel_updates", 32'(upd_cnt), 18);

      // Freeze: three wraps enabled, ten wraps disabled, then resume.
      do_wrap();
      do_wrap();
      chk_duty("fz_w2", 12, 4, 0);
      do_wrap();
      hold_r = int'(duty_r);
      hold_g = int'(duty_g);
      hold_b = int'(duty_b);
      enable = 1'b0;
      for (int w = 0; w < 10; w++) begin
         do_wrap();
         chk("fz_no_update", 32'(update), 0);
      end
      chk_duty("fz_hold", hold_r, hold_g, hold_b);
      chk("fz_phase", 32'(phase), 0);
      enable = 1'b1;
      do_wrap();
      chk("fz_resume_update", 32'(update), 1);
      chk_duty("fz_resume", 12, 8, 0);

      // Advance to phase 3, go mid-step, then reset between edges.
      for (int w = 0; w < 14; w++) begin
         do_wrap();
      end
      chk("mid_phase", 32'(phase), 3);
      chk_duty("mid", 0, 12, 12);
      do_wrap();
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_duty("mid_rst", 12, 0, 0);
      chk("mid_rst_phase", 32'(phase), 0);
      chk("mid_rst_update", 32'(update), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_wrap();
      chk("post_rst_w1", 32'(update), 0);
      do_wrap();
      chk("post_rst_w2", 32'(update), 1);
      chk_duty("post_rst_w2", 12, 4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Colour-wheel sequencer that generates the red, green and blue duty values for the RGB PWM stage. It sits directly upstream of the PWM generator inside `top`. It walks a 6-phase hue wheel, so exactly one channel ramps while another holds full scale. Duty values advance only on PWM period boundaries, which the PWM stage signals with a one-cycle wrap pulse, so the PWM never sees a mid-period duty change.

## Interface

- `PWM_INTERVAL`, default 1200: PWM period in clocks; also the full-scale duty value.
- `STEP_SIZE`, default 4: duty increment per step. Legal range 1..PWM_INTERVAL.
- `STEP_PERIODS`, default 50: number of PWM periods per step. Must be ≥ 1.
- `DW`, derived: `$clog2(PWM_INTERVAL+1)`. This is the duty width. It is not overridable.

Ports:

- `clk` (in, 1): system clock. This is the block's only clock.
- `rst` (in, 1): reset. Asynchronous, active-high.
- `enable` (in, 1): when low, the sequencer freezes.
- `pwm_wrap` (in, 1): one-cycle pulse from the PWM stage on the last clock of each PWM period.
- `duty_r`, `duty_g`, `duty_b` (out, DW each): registered duty values, in the range 0..PWM_INTERVAL.
- `update` (out, 1): one-cycle pulse, high in the first cycle that new duty values are present.
- `phase` (out, 3): current hue phase, 0..5. Provided for debug.

## Operation

Registers:
- Period counter `pc`, range 0..STEP_PERIODS-1.
- Ramp `r`, width DW.
- Phase `ph`, 3 bits.
- The three duty registers and `update`.

Tick generation:
- A tick occurs when `enable && pwm_wrap && pc == STEP_PERIODS-1`. On a tick, `pc` is cleared to 0.
- On `enable && pwm_wrap` without a tick, `pc` increments.
- When `enable` is low, `pc` holds and `pwm_wrap` is ignored.

Ramp and phase, updated on a tick:
- If `r + STEP_SIZE >= PWM_INTERVAL`, then `r` becomes 0 and `ph` advances. Phase 5 wraps to 0.
- Otherwise `r` becomes `r + STEP_SIZE`.
- The sum is computed DW+1 bits wide. The ramp never exceeds PWM_INTERVAL-1.

Phase decode. Here F = PWM_INTERVAL, rise = r, fall = F - r:
- Phase 0: R=F, G=rise, B=0.
- Phase 1: R=fall, G=F, B=0.
- Phase 2: R=0, G=F, B=rise.
- Phase 3: R=0, G=fall, B=F.
- Phase 4: R=rise, G=0, B=F.
- Phase 5: R=F, G=0, B=fall.

The wheel is continuous across phase boundaries because the ramping channel reaches F via the next phase's hold value. Phase codes 6 and 7 are unreachable. If `ph` ever holds 6 or 7, the next tick forces it to 0 and the decode outputs R=F, G=0, B=0.

Duty registers and `update`:
- The duty registers load the decode of the next-state `ph`/`r` on the tick edge.
- `update` is registered and equals the tick.

Reset values (asynchronous on `rst`):
- `pc`=0, `r`=0, `ph`=0.
- `duty_r`=F, `duty_g`=0, `duty_b`=0.
- `update`=0.

Reset asserted mid-ramp discards all state. After reset releases, the first step requires a full STEP_PERIODS wraps.

## Timing

- Latency: the duty values and `update` change on the clock edge that samples the qualifying `pwm_wrap`. The new values are visible in the cycle after the wrap pulse. This is the first clock of the new PWM period.
- Duty outputs are stable for at least STEP_PERIODS×PWM_INTERVAL clocks between changes.
- `enable` is sampled only together with `pwm_wrap`. Toggling it between wraps has no effect.
- A full wheel takes 6×ceil(F/STEP_SIZE) ticks. After that the state returns exactly to its reset values, with `update` as the only difference.
- `pwm_wrap` held high for consecutive cycles counts once per cycle. This is illegal stimulus and is not checked.

## Test plan

The plan uses F=12, STEP_SIZE=4 and STEP_PERIODS=2, with the wrap pulse driven every 12 clocks, unless a line says otherwise.

- Reset: assert `rst` asynchronously with no clock edge. Outputs must be duty=(12,0,0), `update`=0, `phase`=0, immediately.
- First steps:
  - 1st wrap: no `update`.
  - 2nd wrap: one-cycle `update`, duty=(12,4,0).
  - 4th wrap: duty=(12,8,0).
  - 6th wrap: phase=1, duty=(12,12,0).
  - 8th wrap: duty=(8,12,0).
- Full wheel: after 36 wraps, duty=(12,0,0) and phase=0. Exactly 18 `update` pulses have occurred. The check is that every channel is always ≤12 and that adjacent samples never differ by more than 4 on any channel.
- Non-divisible step (STEP_SIZE=5): the ramp sequence within phase 0 must be G=0,5,10, then on the next tick phase=1 with duty=(12,12,0).
- Freeze: drop `enable` after 3 wraps and hold it low for 10 wraps. There must be no `update` and no change in duty values. After re-enable, the next `update` must occur after exactly 1 more wrap, because `pc` was retained at 1.
- Reset mid-operation: assert `rst` in phase 3. Duty must be (12,0,0) at once. After release, the first `update` occurs on the 2nd wrap.
